// File: rtl/gpio_arb_pkg.sv
// Shared types for the two-master local-bus arbiter: FSM state encoding,
// master id type and the default timeout limit.
package gpio_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   typedef logic mid_t;

   localparam int GPIO_ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/gpio_arb_rr_pick.sv
// Two-input round-robin winner select. rr names the master holding priority;
// a lone requester wins regardless of rr.
module gpio_arb_rr_pick
   import gpio_arb_pkg::*;
(
   input  logic [1:0] req,
   input  mid_t       rr,
   output mid_t       win,
   output logic       any
);

   // Contention goes to the priority holder, otherwise whoever is asking
   always_comb begin
      any = |req;
      win = 1'b0;
      if (req == 2'b11) win = rr;
      else if (req[1])  win = 1'b1;
   end

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master round-robin arbiter onto a simple local read/write bus.
// IDLE -> ISSUE (strobes held until slave completes) -> ACK (one-cycle pulse).
// Optional feature macro: GPIO_ARB_TIMEOUT_EN adds an ISSUE timeout that
// completes the transaction with m<i>_err = 1 after TIMEOUT_CYCLES cycles.
module gpio_bus_arb
   import gpio_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = GPIO_ARB_TIMEOUT_DEFAULT
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic                m0_err,
   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic                m1_err,
   output logic [ADDR_W-1:0]   s_waddr,
   output logic [DATA_W-1:0]   s_wdata,
   output logic                s_wen,
   output logic [DATA_W/8-1:0] s_wstrb,
   input  logic                s_wready,
   output logic [ADDR_W-1:0]   s_raddr,
   output logic                s_ren,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic                s_rvalid,
   output logic                busy
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("gpio_bus_arb: TIMEOUT_CYCLES must be at least 1");
   end

   state_t              state;
   mid_t                rr;
   mid_t                gnt;
   mid_t                win;
   logic                any_req;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;
   logic [DATA_W/8-1:0] lat_wstrb;
   logic                done;
   logic [DATA_W-1:0]   cap_data;

   gpio_arb_rr_pick u_pick (
      .req (({m1_req, m0_req})),
      .rr  (rr),
      .win (win),
      .any (any_req)
   );

   // Bus strobes and fields exist only in ISSUE; everything else reads zero
   assign s_wen    = (state == ST_ISSUE) &&  lat_we;
   assign s_ren    = (state == ST_ISSUE) && !lat_we;
   assign s_waddr  = s_wen ? lat_addr  : '0;
   assign s_wdata  = s_wen ? lat_wdata : '0;
   assign s_wstrb  = s_wen ? lat_wstrb : '0;
   assign s_raddr  = s_ren ? lat_addr  : '0;
   assign busy     = (state != ST_IDLE);
   assign done     = (s_wen && s_wready) || (s_ren && s_rvalid);
   assign cap_data = lat_we ? '0 : s_rdata;
   assign m0_ack   = (state == ST_ACK) && (gnt == 1'b0);
   assign m1_ack   = (state == ST_ACK) && (gnt == 1'b1);

`ifdef GPIO_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] to_cnt;
   logic             err_q;

   assign m0_err = m0_ack && err_q;
   assign m1_err = m1_ack && err_q;
`else
   assign m0_err = 1'b0;
   assign m1_err = 1'b0;
`endif

   // Control FSM, round-robin pointer and per-master read-data holding regs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         rr       <= 1'b0;
         gnt      <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
`ifdef GPIO_ARB_TIMEOUT_EN
         to_cnt   <= '0;
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state <= ST_ISSUE;
                  gnt   <= win;
                  rr    <= ~win;
`ifdef GPIO_ARB_TIMEOUT_EN
                  to_cnt <= '0;
                  err_q  <= 1'b0;
`endif
               end
            end
            ST_ISSUE: begin
               if (done) begin
                  state <= ST_ACK;
                  if (gnt == 1'b0) m0_rdata <= cap_data;
                  else             m1_rdata <= cap_data;
               end
`ifdef GPIO_ARB_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  state <= ST_ACK;
                  err_q <= 1'b1;
                  if (gnt == 1'b0) m0_rdata <= '0;
                  else             m1_rdata <= '0;
               end else begin
                  to_cnt <= to_cnt + CNT_W'(1);
               end
`endif
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Winner's transaction fields captured at grant; held through ISSUE
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && any_req) begin
         lat_we    <= win ? m1_we    : m0_we;
         lat_addr  <= win ? m1_addr  : m0_addr;
         lat_wdata <= win ? m1_wdata : m0_wdata;
         lat_wstrb <= win ? m1_wstrb : m0_wstrb;
      end
   end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Directed bench for gpio_bus_arb. Inputs are driven and outputs sampled on
// the falling edge; the design acts on the rising edge.
module tb_gpio_bus_arb;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m1_req, m1_we;
   logic [AW-1:0] m0_addr, m1_addr;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [3:0]    m0_wstrb, m1_wstrb;
   logic          m0_ack, m1_ack, m0_err, m1_err;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic [AW-1:0] s_waddr, s_raddr;
   logic [DW-1:0] s_wdata, s_rdata;
   logic [3:0]    s_wstrb;
   logic          s_wen, s_ren, s_wready, s_rvalid, busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gpio_bus_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wen(s_wen), .s_wstrb(s_wstrb),
      .s_wready(s_wready), .s_raddr(s_raddr), .s_ren(s_ren), .s_rdata(s_rdata),
      .s_rvalid(s_rvalid), .busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One rising edge, then settle at the falling edge
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
      s_wready = 0; s_rvalid = 0; s_rdata = '0;
      @(negedge clk);
      cyc(); cyc();

      // Reset state
      check("rst_busy", busy, 0);
      check("rst_wen", s_wen, 0);
      check("rst_ren", s_ren, 0);
      check("rst_acks", {m1_ack, m0_ack}, 0);
      check("rst_rdata0", m0_rdata, 0);
      check("rst_rdata1", m1_rdata, 0);
      rst = 1'b0;

      // m0 write, zero-wait slave
      m0_req = 1; m0_we = 1; m0_addr = 32'h4; m0_wdata = 32'h0000_0ABC; m0_wstrb = 4'h3;
      s_wready = 1;
      cyc();
      check("wr_wen", s_wen, 1);
      check("wr_ren", s_ren, 0);
      check("wr_waddr", s_waddr, 32'h4);
      check("wr_wdata", s_wdata, 32'h0000_0ABC);
      check("wr_wstrb", s_wstrb, 4'h3);
      check("wr_busy", busy, 1);
      check("wr_noack_yet", m0_ack, 0);
      cyc();
      check("wr_wen_off", s_wen, 0);
      check("wr_waddr_zero", s_waddr, 0);
      check("wr_ack", {m1_ack, m0_ack}, 2'b01);
      check("wr_err", m0_err, 0);
      check("wr_rdata", m0_rdata, 0);
      m0_req = 0; s_wready = 0;
      cyc();
      check("wr_ack_one_cycle", m0_ack, 0);
      check("wr_idle", busy, 0);

      // m1 read, three wait cycles before rvalid
      m1_req = 1; m1_we = 0; m1_addr = 32'h0;
      s_rdata = 32'hDEAD_BEEF;
      cyc();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            s_rvalid = 1; s_rdata = 32'h1230_00A0;
         end
         check("rd_ren_held", s_ren, 1);
         check("rd_wen_low", s_wen, 0);
         check("rd_noack", {m1_ack, m0_ack}, 0);
         cyc();
      end
      check("rd_ack", {m1_ack, m0_ack}, 2'b10);
      check("rd_rdata", m1_rdata, 32'h1230_00A0);
      check("rd_err", m1_err, 0);
      check("rd_ren_off", s_ren, 0);
      m1_req = 0; s_rvalid = 0; s_rdata = '0;
      cyc();
      check("rd_rdata_hold", m1_rdata, 32'h1230_00A0);
      check("rd_ack_off", m1_ack, 0);

      // Both masters requesting continuously from reset: grants alternate
      rst = 1;
      m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h11; m0_wstrb = 4'hF;
      m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h22; m1_wstrb = 4'hF;
      s_wready = 1;
      cyc(); cyc();
      rst = 0;
      for (int t = 0; t < 4; t++) begin
         cyc();
         check("rr_waddr", s_waddr, (t % 2 == 0) ? 32'h100 : 32'h200);
         cyc();
         check("rr_grant", {m1_ack, m0_ack}, (t % 2 == 0) ? 2'b01 : 2'b10);
         if (t % 2 == 0) m0_req = 0; else m1_req = 0;
         cyc();
         m0_req = 1; m1_req = 1;
      end
      m0_req = 0; m1_req = 0; s_wready = 0;
      cyc();

      // m0 write with a slave that never accepts
      m0_req = 1; m0_we = 1; m0_addr = 32'h8; m0_wdata = 32'h55; m0_wstrb = 4'h1;
      cyc();
`ifdef GPIO_ARB_TIMEOUT_EN
      for (int k = 0; k < TO; k++) begin
         check("to_wen_held", s_wen, 1);
         cyc();
      end
      check("to_ack", {m1_ack, m0_ack}, 2'b01);
      check("to_err", m0_err, 1);
      check("to_wen_off", s_wen, 0);
      check("to_rdata", m0_rdata, 0);
`else
      for (int k = 0; k < TO + 2; k++) begin
         check("nto_wen_held", s_wen, 1);
         check("nto_noack", m0_ack, 0);
         cyc();
      end
      s_wready = 1;
      check("nto_wen_last", s_wen, 1);
      cyc();
      check("nto_ack", {m1_ack, m0_ack}, 2'b01);
      check("nto_err", m0_err, 0);
`endif
      m0_req = 0; s_wready = 0;
      cyc();

      // Reset during a read ISSUE aborts it and restores m0 priority
      m0_req = 1; m0_we = 0; m0_addr = 32'h30;
      cyc();
      check("ab_ren", s_ren, 1);
      check("ab_raddr", s_raddr, 32'h30);
      rst = 1;
      cyc();
      check("ab_ren_off", s_ren, 0);
      check("ab_noack", {m1_ack, m0_ack}, 0);
      check("ab_busy", busy, 0);
      check("ab_rdata1_clr", m1_rdata, 0);
      rst = 0;
      m1_req = 1; m1_we = 0; m1_addr = 32'h40;
      s_rvalid = 1; s_rdata = 32'hCAFE_0001;
      cyc();
      check("ab_regrant_addr", s_raddr, 32'h30);
      cyc();
      check("ab_regrant_m0", {m1_ack, m0_ack}, 2'b01);
      check("ab_regrant_data", m0_rdata, 32'hCAFE_0001);
      m0_req = 0; m1_req = 0; s_rvalid = 0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/gpio_bus_arb.md
GPIO_BUS_ARB -- requirements
Module: gpio_bus_arb

Interface
REQ-001 Parameters SHALL be as follows:
- ADDR_W, 32: address width.
- DATA_W, 32: data width; strobe width = DATA_W/8.
- TIMEOUT_CYCLES, 16: timeout limit in cycles; used only when GPIO_ARB_TIMEOUT_EN is defined.

REQ-002 Ports SHALL be as follows, with i in {0,1}:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- m<i>_req  in  1  requester i transaction request.
- m<i>_we  in  1  1 = write, 0 = read.
- m<i>_addr  in  ADDR_W  byte address.
- m<i>_wdata  in  DATA_W  write data.
- m<i>_wstrb  in  DATA_W/8  byte enables.
- m<i>_ack  out  1  one-cycle completion pulse.
- m<i>_rdata  out  DATA_W  read data; valid while m<i>_ack = 1.
- m<i>_err  out  1  timeout error; valid while m<i>_ack = 1.
- s_waddr  out  ADDR_W  local-bus write address.
- s_wdata  out  DATA_W  local-bus write data.
- s_wen  out  1  local-bus write enable.
- s_wstrb  out  DATA_W/8  local-bus byte strobes.
- s_wready  in  1  slave write accepted.
- s_raddr  out  ADDR_W  local-bus read address.
- s_ren  out  1  local-bus read enable.
- s_rdata  in  DATA_W  slave read data.
- s_rvalid  in  1  slave read data valid.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and ACK.
REQ-004 IDLE: if any m<i>_req = 1, the block SHALL latch the winner's we/addr/wdata/wstrb and its id, and move to ISSUE at the next edge.
REQ-005 Arbitration SHALL be round-robin using pointer rr, where rr = id of the master with priority.
- On a grant, rr SHALL be set to the other master.
- A single requester SHALL win regardless of rr.
REQ-006 ISSUE, write: s_wen = 1, with s_waddr/s_wdata/s_wstrb driven from the latched fields.
- Completion = s_wen && s_wready in the same cycle.
REQ-007 ISSUE, read: s_ren = 1, with s_raddr driven from the latched address.
- Completion = s_ren && s_rvalid; s_rdata SHALL be captured on that edge.
REQ-008 Strobes SHALL be held in ISSUE until completion; at the completion edge the FSM SHALL move to ACK.
REQ-009 ACK: the granted master's m<i>_ack = 1 for exactly one cycle, with m<i>_rdata valid (0 for writes). The FSM SHALL then return to IDLE.
REQ-010 Requests present during ISSUE and ACK SHALL NOT be sampled; a requester still holding req in IDLE is treated as a new request.
REQ-011 Latency with a zero-wait slave: req seen at edge N -> ISSUE cycle N+1 -> ACK cycle N+2 -> IDLE N+3; back-to-back throughput is 1 transaction per 3 cycles.
REQ-012 Outside ISSUE, s_wen and s_ren SHALL be 0, and s_waddr/s_raddr/s_wdata/s_wstrb SHALL be 0.
REQ-013 s_wen and s_ren SHALL never be high in the same cycle.
REQ-014 The non-granted master's ack/err SHALL stay 0; m<i>_rdata SHALL hold its value between acks.
REQ-015 Requesters SHALL hold req and all fields stable until ack; the block SHALL NOT check this.

Reset
REQ-016 While rst = 1, at each edge:
- state = IDLE, rr = 0 (m0 priority), all ack/err/strobes/busy = 0, all rdata = 0.
REQ-017 Reset during ISSUE or ACK SHALL abort the transaction without an ack; strobes SHALL be 0 from the cycle after the reset edge.

Configuration
REQ-018 With GPIO_ARB_TIMEOUT_EN defined:
- A counter SHALL clear on entry to ISSUE and increment each ISSUE cycle.
- If TIMEOUT_CYCLES ISSUE cycles pass without completion, the FSM SHALL move to ACK, drop strobes, and present m<i>_err = 1 with m<i>_rdata = 0.
- Completion in the final counted cycle SHALL take precedence over timeout.
REQ-019 Without GPIO_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, no counter logic SHALL exist, and m<i>_err SHALL be tied to 0.

Structure
REQ-020 Package gpio_arb_pkg SHALL hold:
- the state enum (IDLE/ISSUE/ACK),
- the master-id type (1 bit),
- the default TIMEOUT_CYCLES constant.
REQ-021 Sub-module gpio_arb_rr_pick (2-input round-robin winner from req and rr) SHALL be used; all other logic SHALL be flat.

Verification
REQ-022 m0 write addr 0x4, wdata 0x0000_0ABC, wstrb 0x3, s_wready = 1 -> s_wen high exactly 1 cycle, m0_ack pulse 2 cycles after req edge, m0_err = 0.
REQ-023 m1 read addr 0x0, s_rvalid after 3 wait cycles, s_rdata 0x1230_00A0 -> s_ren held 4 cycles, m1_ack with m1_rdata 0x1230_00A0.
REQ-024 Both req asserted continuously from reset, both releasing req in their ack cycle -> grants strictly alternate m0, m1, m0, m1; no master is starved.
REQ-025 Timeout enabled, TIMEOUT_CYCLES = 4, s_wready held 0 -> s_wen high 4 cycles, then m0_ack = 1 and m0_err = 1; without the macro, s_wen stays high until s_wready.
REQ-026 rst asserted in an ISSUE cycle of a read -> no m<i>_ack, s_ren = 0 next cycle, rr = 0; the next simultaneous request grants m0.
